// File: rtl/utopia_cell_router.sv
// utopia_cell_router: NUM_RX x NUM_TX Utopia L1 ATM cell router.
// Round-robin Rx, HEC check, VPI lookup/rewrite, multicast Tx.
module utopia_cell_router #(
  parameter int NUM_RX = 4,
  parameter int NUM_TX = 4,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_RX-1:0]   rx_soc,
  input  logic [8*NUM_RX-1:0] rx_data,
  input  logic [NUM_RX-1:0]   rx_clav,
  output logic [NUM_RX-1:0]   rx_en,
  output logic [NUM_TX-1:0]   tx_soc,
  output logic [8*NUM_TX-1:0] tx_data,
  input  logic [NUM_TX-1:0]   tx_clav,
  output logic [NUM_TX-1:0]   tx_en,
  input  logic                cfg_we,
  input  logic [7:0]          cfg_addr,
  input  logic [NUM_TX+7:0]   cfg_wdata,
  output logic [NUM_TX+7:0]   cfg_rdata,
  output logic [CNT_W-1:0]    cells_fwd,
  output logic [CNT_W-1:0]    cells_drop
);
  localparam int GW = (NUM_RX > 1) ? $clog2(NUM_RX) : 1;
  localparam int EW = NUM_TX + 8;

  typedef enum logic [2:0] {
    IDLE, RX, CHECK, LOOKUP, TXWAIT, TX
  } state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       gnt_q, gnt_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [NUM_RX-1:0]   rx_en_q, rx_en_d;
  logic [NUM_TX-1:0]   tx_en_q, tx_en_d;
  logic [NUM_TX-1:0]   tx_soc_q, tx_soc_d;
  logic [8*NUM_TX-1:0] tx_data_q, tx_data_d;
  logic [NUM_TX-1:0]   mask_q, mask_d;
  logic [EW-1:0]       rdata_q, rdata_d;
  logic [CNT_W-1:0]    fwd_q, fwd_d;
  logic [CNT_W-1:0]    drop_q, drop_d;

  logic [7:0]    buf_q [53];
  logic [EW-1:0] tbl_q [256];

  logic          found;
  logic [GW-1:0] pick;
  logic [GW:0]   sum;
  logic [GW-1:0] cand;
  logic [7:0]    vpi;
  logic [EW-1:0] ent;
  logic [7:0]    hdr0, hdr1, hec_new, rx_byte, txb;
  logic [5:0]    tx_idx;
  logic          hec_ok;
  logic          buf_we, hdr_we, drop_ev, fwd_ev, tx_act;

  // ATM HEC: CRC-8 x^8+x^2+x+1, MSB first, coset 0x55
  function automatic logic [7:0] hec_f(input logic [31:0] h);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 31; i >= 0; i--) begin
      if (c[7] ^ h[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else             c = {c[6:0], 1'b0};
    end
    return c ^ 8'h55;
  endfunction

  // round-robin search starting after the last grant
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_RX; i++) begin
      sum  = {1'b0, gnt_q} + (GW+1)'(i);
      cand = (sum >= (GW+1)'(NUM_RX)) ?
             GW'(sum - (GW+1)'(NUM_RX)) : sum[GW-1:0];
      if (!found && rx_clav[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // datapath: header check, lookup, rewrite, byte selects
  always_comb begin
    vpi     = {buf_q[0][3:0], buf_q[1][7:4]};
    ent     = tbl_q[vpi];
    hdr0    = {buf_q[0][7:4], ent[7:4]};
    hdr1    = {ent[3:0], buf_q[1][3:0]};
    hec_new = hec_f({hdr0, hdr1, buf_q[2], buf_q[3]});
    hec_ok  = hec_f({buf_q[0], buf_q[1], buf_q[2], buf_q[3]})
              == buf_q[4];
    rx_byte = rx_data[{gnt_q, 3'b000} +: 8];
    tx_idx  = (state_q == TX && cnt_q < 6'd53) ? cnt_q : 6'd0;
    txb     = buf_q[tx_idx];
    rdata_d = tbl_q[cfg_addr];
  end

  // cell FSM: next state, port enables, counters
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    rx_en_d   = rx_en_q;
    tx_en_d   = '1;
    tx_soc_d  = '0;
    tx_data_d = '0;
    mask_d    = mask_q;
    fwd_d     = fwd_q;
    drop_d    = drop_q;
    buf_we    = 1'b0;
    hdr_we    = 1'b0;
    drop_ev   = 1'b0;
    fwd_ev    = 1'b0;
    tx_act    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d          = pick;
          rx_en_d        = '1;
          rx_en_d[pick]  = 1'b0;
          cnt_d          = '0;
          state_d        = RX;
        end
      end
      RX: begin
        if ((cnt_q == 6'd0) != rx_soc[gnt_q]) begin
          rx_en_d = '1;
          drop_ev = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          buf_we = 1'b1;
          if (cnt_q == 6'd52) begin
            rx_en_d = '1;
            cnt_d   = '0;
            state_d = CHECK;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      CHECK: begin
        if (!hec_ok) begin
          drop_ev = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (ent[EW-1:8] == '0) begin
          drop_ev = 1'b1;
          state_d = IDLE;
        end else begin
          mask_d  = ent[EW-1:8];
          hdr_we  = 1'b1;
          state_d = TXWAIT;
        end
      end
      TXWAIT: begin
        if ((tx_clav & mask_q) == mask_q) begin
          tx_act   = 1'b1;
          tx_soc_d = mask_q;
          cnt_d    = 6'd1;
          state_d  = TX;
        end
      end
      TX: begin
        if (cnt_q == 6'd53) begin
          fwd_ev  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          tx_act = 1'b1;
          cnt_d  = cnt_q + 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (tx_act) begin
      tx_en_d = ~mask_q;
      for (int p = 0; p < NUM_TX; p++)
        tx_data_d[8*p +: 8] = mask_q[p] ? txb : 8'h00;
    end
    if (drop_ev && drop_q != '1) drop_d = drop_q + 1'b1;
    if (fwd_ev && fwd_q != '1)   fwd_d  = fwd_q + 1'b1;
  end

  // control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= GW'(NUM_RX - 1);
      cnt_q     <= '0;
      rx_en_q   <= '1;
      tx_en_q   <= '1;
      tx_soc_q  <= '0;
      tx_data_q <= '0;
      mask_q    <= '0;
      rdata_q   <= '0;
      fwd_q     <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      rx_en_q   <= rx_en_d;
      tx_en_q   <= tx_en_d;
      tx_soc_q  <= tx_soc_d;
      tx_data_q <= tx_data_d;
      mask_q    <= mask_d;
      rdata_q   <= rdata_d;
      fwd_q     <= fwd_d;
      drop_q    <= drop_d;
    end
  end

  // cell buffer and route table survive reset
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[cnt_q] <= rx_byte;
    if (hdr_we) begin
      buf_q[0] <= hdr0;
      buf_q[1] <= hdr1;
      buf_q[4] <= hec_new;
    end
    if (cfg_we) tbl_q[cfg_addr] <= cfg_wdata;
  end

  assign rx_en      = rx_en_q;
  assign tx_en      = tx_en_q;
  assign tx_soc     = tx_soc_q;
  assign tx_data    = tx_data_q;
  assign cfg_rdata  = rdata_q;
  assign cells_fwd  = fwd_q;
  assign cells_drop = drop_q;

endmodule
